// File: rtl/help_pager_if.sv
// Keypad/display bundle between the help pager, keypad event logic, help decoder and display driver.
// The master modport is the environment side; the slave modport is the pager itself.
interface help_pager_if;
  logic        help_btn;
  logic        next_btn;
  logic        prev_btn;
  logic        exit_btn;
  logic [19:0] calc_in;
  logic [19:0] help_in;
  logic [3:0]  state_out;
  logic [2:0]  page_idx;
  logic        paused;
  logic        disp_sel;
  logic [19:0] disp_out;

  modport master (
    output help_btn, next_btn, prev_btn, exit_btn, calc_in, help_in,
    input  state_out, page_idx, paused, disp_sel, disp_out
  );

  modport slave (
    input  help_btn, next_btn, prev_btn, exit_btn, calc_in, help_in,
    output state_out, page_idx, paused, disp_sel, disp_out
  );
endinterface

// File: rtl/help_pager.sv
// Help-text pager: steps the help decoder through 7 pages (auto-advance, manual step, pause) and
// registers either calculator digits or help glyphs to the display. Optional: HELP_PAGER_BLINK_EN.
module help_pager #(
  parameter int DWELL_CYC = 50_000_000,
  parameter int BLINK_CYC = 12_500_000
) (
  input logic         clk,
  input logic         rst,
  help_pager_if.slave bus
);

  localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [19:0] BLANK = {4{5'd31}};

  typedef enum logic [1:0] {IDLE, SHOW, PAUSE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [3:0]      code_q;
  logic            paused_q;
  logic            disp_sel_q;
  logic [19:0]     disp_q;
  logic            blank;

  if (DWELL_CYC < 2 || BLINK_CYC < 1) begin : g_bad_param
    $error("help_pager: DWELL_CYC must be >= 2 and BLINK_CYC >= 1");
  end

  function automatic logic [3:0] page_code(input logic [2:0] idx);
    case (idx)
      3'd0:    return 4'd6;
      3'd1:    return 4'd8;
      3'd2:    return 4'd9;
      3'd3:    return 4'd10;
      3'd4:    return 4'd11;
      3'd5:    return 4'd12;
      3'd6:    return 4'd13;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] idx_inc(input logic [2:0] idx);
    return (idx == 3'd6) ? 3'd0 : idx + 3'd1;
  endfunction

  // NOTE: every next-state signal gets a default first, so no path can leave one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    if (state_q != IDLE && bus.exit_btn) begin
      state_d = IDLE;
      idx_d   = 3'd0;
      dwell_d = '0;
    end else if (bus.help_btn) begin
      case (state_q)
        IDLE: begin
          state_d = SHOW;
          idx_d   = 3'd0;
          dwell_d = '0;
        end
        SHOW:    state_d = PAUSE;
        default: state_d = SHOW;
      endcase
    end else if (state_q != IDLE && (bus.next_btn ^ bus.prev_btn)) begin
      idx_d   = bus.next_btn ? idx_inc(idx_q) : ((idx_q == 3'd0) ? 3'd6 : idx_q - 3'd1);
      dwell_d = '0;
    end else if (state_q == SHOW) begin
      // Last cycle of the dwell window: advance so each page is shown exactly DWELL_CYC cycles.
      if (dwell_q == DW'(DWELL_CYC - 1)) begin
        idx_d   = idx_inc(idx_q);
        dwell_d = '0;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

`ifdef HELP_PAGER_BLINK_EN
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  logic [BW-1:0] blink_q;
  logic          phase_q;
  assign blank = (state_q == PAUSE) && phase_q;
`else
  assign blank = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      dwell_q    <= '0;
      code_q     <= 4'd0;
      paused_q   <= 1'b0;
      disp_sel_q <= 1'b0;
      disp_q     <= 20'd0;
`ifdef HELP_PAGER_BLINK_EN
      blink_q    <= '0;
      phase_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dwell_q    <= dwell_d;
      code_q     <= (state_d == IDLE) ? 4'd0 : page_code(idx_d);
      paused_q   <= (state_d == PAUSE);
      disp_sel_q <= (state_q != IDLE);
      // help_in answers the code currently on state_out, so it pairs with the current state.
      disp_q     <= (state_q == IDLE) ? bus.calc_in : (blank ? BLANK : bus.help_in);
`ifdef HELP_PAGER_BLINK_EN
      if (state_d != PAUSE) begin
        blink_q <= '0;
        phase_q <= 1'b0;
      end else if (state_q == PAUSE) begin
        if (blink_q == BW'(BLINK_CYC - 1)) begin
          blink_q <= '0;
          phase_q <= ~phase_q;
        end else begin
          blink_q <= blink_q + 1'b1;
        end
      end
`endif
    end
  end

  assign bus.state_out = code_q;
  assign bus.page_idx  = idx_q;
  assign bus.paused    = paused_q;
  assign bus.disp_sel  = disp_sel_q;
  assign bus.disp_out  = disp_q;

endmodule

// File: tb/tb_help_pager.sv
// Scoreboard bench for help_pager: a page/mode reference model predicts each cycle's outputs into a
// queue; an independent monitor pops and compares one cycle of outputs after every clock edge.
module tb_help_pager;
  localparam int DWELL = 8;
  localparam int BLINK = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  help_pager_if ifc ();

  help_pager #(.DWELL_CYC(DWELL), .BLINK_CYC(BLINK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // Help decoder stand-in: a distinct glyph word for every page code.
  function automatic logic [19:0] glyph(input logic [3:0] c);
    logic [4:0] c5;
    c5 = {1'b0, c};
    return {c5, c5 ^ 5'h15, c5 + 5'd3, ~c5};
  endfunction

  assign ifc.help_in = glyph(ifc.state_out);

  typedef struct {
    logic [3:0]  code;
    logic [2:0]  idx;
    logic        paused;
    logic        sel;
    logic [19:0] disp;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: mode 0 = idle, 1 = showing, 2 = paused.
  int m_mode, m_page, m_dwell, m_bcnt;
  bit m_phase;
  int codes[7] = '{6, 8, 9, 10, 11, 12, 13};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_page = 0; m_dwell = 0; m_bcnt = 0; m_phase = 0;
  endtask

  // Drive one cycle of events and queue the outputs expected after the following edge.
  task automatic step(input bit h, input bit n, input bit p, input bit e, input logic [19:0] calc);
    exp_t x;
    int   prev_mode;
    @(negedge clk);
    ifc.help_btn = h; ifc.next_btn = n; ifc.prev_btn = p; ifc.exit_btn = e; ifc.calc_in = calc;
    x.sel = (m_mode != 0);
    if (m_mode == 0)                    x.disp = calc;
    else if (m_mode == 2 && m_phase)    x.disp = {4{5'd31}};
    else                                x.disp = glyph(4'(codes[m_page]));
    prev_mode = m_mode;
    if (e && m_mode != 0) begin
      m_mode = 0; m_page = 0; m_dwell = 0;
    end else if (h) begin
      if (m_mode == 0) begin m_mode = 1; m_page = 0; m_dwell = 0; end
      else m_mode = (m_mode == 1) ? 2 : 1;
    end else if ((n != p) && m_mode != 0) begin
      m_page  = n ? (m_page + 1) % 7 : (m_page + 6) % 7;
      m_dwell = 0;
    end else if (m_mode == 1) begin
      m_dwell++;
      if (m_dwell == DWELL) begin m_page = (m_page + 1) % 7; m_dwell = 0; end
    end
`ifdef HELP_PAGER_BLINK_EN
    if (m_mode != 2) begin
      m_bcnt = 0; m_phase = 0;
    end else if (prev_mode == 2) begin
      m_bcnt++;
      if (m_bcnt == BLINK) begin m_bcnt = 0; m_phase = !m_phase; end
    end
`else
    m_bcnt = prev_mode;
`endif
    x.code   = (m_mode == 0) ? 4'd0 : 4'(codes[m_page]);
    x.idx    = 3'(m_page);
    x.paused = (m_mode == 2);
    exp_q.push_back(x);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 20'($urandom));
  endtask

  // Monitor: compares the DUT against the oldest prediction, 1 time unit after each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("state_out", 32'(ifc.state_out), 32'(x.code));
        check("page_idx",  32'(ifc.page_idx),  32'(x.idx));
        check("paused",    32'(ifc.paused),    32'(x.paused));
        check("disp_sel",  32'(ifc.disp_sel),  32'(x.sel));
        check("disp_out",  32'(ifc.disp_out),  32'(x.disp));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 2000000");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state_out"}, 32'(ifc.state_out), 32'd0);
    check({tag, "_page_idx"},  32'(ifc.page_idx),  32'd0);
    check({tag, "_paused"},    32'(ifc.paused),    32'd0);
    check({tag, "_disp_sel"},  32'(ifc.disp_sel),  32'd0);
    check({tag, "_disp_out"},  32'(ifc.disp_out),  32'd0);
  endtask

  initial begin
    rst = 1'b1;
    ifc.help_btn = 0; ifc.next_btn = 0; ifc.prev_btn = 0; ifc.exit_btn = 0;
    ifc.calc_in = 20'hABCDE;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Idle: calculator passes through; next/prev/exit ignored.
    step(0, 0, 0, 0, 20'h12345);
    step(0, 1, 0, 0, 20'h0F0F0);
    step(0, 0, 1, 1, 20'h54321);

    // Enter help, let it auto-advance past the 6 -> 0 wrap.
    step(1, 0, 0, 0, 20'h11111);
    idle(60);

    // Manual stepping from idx 0, including next+prev together.
    step(0, 0, 0, 1, 20'h22222);
    step(1, 0, 0, 0, 20'h33333);
    step(0, 0, 1, 0, 20'h44444);
    step(0, 1, 0, 0, 20'h55555);
    step(0, 1, 0, 0, 20'h66666);
    step(0, 1, 1, 0, 20'h77777);
    idle(10);

    // Pause at dwell 5, hold 20 cycles, resume: advance 3 cycles after resume.
    step(0, 0, 0, 1, 20'h88888);
    step(1, 0, 0, 0, 20'h99999);
    idle(5);
    step(1, 0, 0, 0, 20'hAAAAA);
    idle(20);
    step(1, 0, 0, 0, 20'hBBBBB);
    idle(5);

    // Exit with next in the same cycle while paused.
    step(1, 0, 0, 0, 20'hCCCCC);
    idle(3);
    step(0, 1, 0, 1, 20'hDDDDD);
    step(0, 0, 0, 0, 20'hEEEEE);

    // Async reset mid-SHOW at idx 3.
    step(1, 0, 0, 0, 20'h01234);
    step(0, 1, 0, 0, 20'h01234);
    step(0, 1, 0, 0, 20'h01234);
    step(0, 1, 0, 0, 20'h01234);
    step(0, 0, 0, 0, 20'h01234);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(0, 0, 0, 0, 20'h12345);

    // Randomized events: sparse button pulses, random calculator digits.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0), 20'($urandom));
    end
    idle(1);

    @(negedge clk);
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
